// File: rtl/upd_pkg.sv
// upd_pkg
// Shared definitions for the fast-PHY packer that feeds the IQ and noise
// FIFOs of the slow-PHY-to-LLR sender.
//   - sample width, FIFO word width and the lane counts derived from them
//   - FSM state encoding of the packer top level
//   - saturating 16-bit increment used by all per-user counters
package upd_pkg;

    localparam int UPD_DATA_WIDTH     = 16;
    localparam int UPD_WORD_WIDTH     = 128;
    // One RE occupies an I and a Q sample.
    localparam int UPD_IQ_RE_PER_WORD = UPD_WORD_WIDTH / (2 * UPD_DATA_WIDTH);
    localparam int UPD_NOISE_PER_WORD = UPD_WORD_WIDTH / UPD_DATA_WIDTH;
    localparam int UPD_COUNT_WIDTH    = 16;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PACK        = 3'd1,
        ST_FLUSH_IQ    = 3'd2,
        ST_FLUSH_NOISE = 3'd3,
        ST_DONE        = 3'd4
    } upd_state_e;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [UPD_COUNT_WIDTH-1:0] sat_inc(
        input logic [UPD_COUNT_WIDTH-1:0] value
    );
        if (value == {UPD_COUNT_WIDTH{1'b1}}) begin
            return value;
        end
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/upd_lane_packer.sv
// upd_lane_packer
// Collects LANES samples of LANE_WIDTH bits into one FIFO word, lane 0 in
// the least significant position, in arrival order.
//   i_core_clk   clock
//   i_rx_rst     synchronous active-high reset
//   i_clear      discard the partial word without writing it
//   i_valid      sample present on i_data
//   i_data       sample to insert at the current lane
//   i_flush      emit the partial word (unfilled lanes zero) if non-empty
//   i_fifo_full  almost-full flag of the destination FIFO
//   o_wr_en      registered write strobe
//   o_wr_data    registered packed word
//   o_drop       combinational: a word is being emitted this cycle but the
//                FIFO is full, so it is discarded instead of written
module upd_lane_packer #(
    parameter int LANES      = 4,
    parameter int LANE_WIDTH = 32
) (
    input  logic                        i_core_clk,
    input  logic                        i_rx_rst,
    input  logic                        i_clear,
    input  logic                        i_valid,
    input  logic [LANE_WIDTH-1:0]       i_data,
    input  logic                        i_flush,
    input  logic                        i_fifo_full,
    output logic                        o_wr_en,
    output logic [LANES*LANE_WIDTH-1:0] o_wr_data,
    output logic                        o_drop
);

    localparam int WORD_WIDTH = LANES * LANE_WIDTH;
    localparam int IDX_WIDTH  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_LANE = IDX_WIDTH'(LANES - 1);

    logic [IDX_WIDTH-1:0]  lane_idx_reg;
    logic [WORD_WIDTH-1:0] word_reg;
    logic [WORD_WIDTH-1:0] word_ins;
    logic                  wr_en_reg;
    logic [WORD_WIDTH-1:0] wr_data_reg;
    logic                  complete;
    logic                  flush_emit;
    logic                  emit;
    logic [WORD_WIDTH-1:0] emit_word;

    // The word with the incoming sample placed at the current lane. Lanes
    // above the index are still zero because the word register is cleared
    // every time a word is emitted or discarded.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign word_ins[gi*LANE_WIDTH +: LANE_WIDTH] =
                (lane_idx_reg == IDX_WIDTH'(gi)) ? i_data
                                                 : word_reg[gi*LANE_WIDTH +: LANE_WIDTH];
        end
    endgenerate

    assign complete   = i_valid && (lane_idx_reg == LAST_LANE);
    assign flush_emit = i_flush && (lane_idx_reg != '0);
    assign emit       = !i_clear && (complete || flush_emit);
    assign emit_word  = complete ? word_ins : word_reg;
    assign o_drop     = emit && i_fifo_full;

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            lane_idx_reg <= '0;
            word_reg     <= '0;
            wr_en_reg    <= 1'b0;
            wr_data_reg  <= '0;
        end else begin
            wr_en_reg <= 1'b0;
            if (i_clear) begin
                lane_idx_reg <= '0;
                word_reg     <= '0;
            end else if (emit) begin
                // Written or dropped, the lane index wraps either way.
                lane_idx_reg <= '0;
                word_reg     <= '0;
                if (!i_fifo_full) begin
                    wr_en_reg   <= 1'b1;
                    wr_data_reg <= emit_word;
                end
            end else if (i_valid) begin
                word_reg     <= word_ins;
                lane_idx_reg <= lane_idx_reg + 1'b1;
            end
        end
    end

    assign o_wr_en   = wr_en_reg;
    assign o_wr_data = wr_data_reg;

endmodule

// File: rtl/upd_fast_phy_packer.sv
// upd_fast_phy_packer
// Accepts one RE of IQ and one noise sample per cycle from the fast PHY,
// packs them into FIFO words, frames each user (start, end, flush of partial
// words), and reports overflow and IQ/noise count consistency.
//   i_core_clk / i_rx_rst            clock, synchronous active-high reset
//   i_user_start / i_user_end        one-cycle user framing pulses
//   i_user_iq_noise_rate             REs covered by one noise sample (0 = 1)
//   i_iq_valid, i_iq_i, i_iq_q       IQ sample of one RE
//   i_noise_valid, i_noise_data      noise sample
//   i_iq_fifo_full, i_noise_fifo_full almost-full flags of the two FIFOs
//   o_iq_fifo_wr_en/_wr_data         IQ FIFO write port (4 REs per word)
//   o_noise_fifo_wr_en/_wr_data      noise FIFO write port (8 samples per word)
//   o_re_count, o_noise_count        samples accepted for the current user
//   o_overflow                       sticky: a word was dropped on full
//   o_noise_mismatch                 sticky: noise count != ceil(REs / rate)
//   o_user_done                      one-cycle pulse after the flush
module upd_fast_phy_packer
    import upd_pkg::*;
#(
    parameter int DATA_WIDTH     = UPD_DATA_WIDTH,
    parameter int IQ_RE_PER_WORD = UPD_IQ_RE_PER_WORD,
    parameter int NOISE_PER_WORD = UPD_NOISE_PER_WORD
) (
    input  logic                                   i_core_clk,
    input  logic                                   i_rx_rst,
    input  logic                                   i_user_start,
    input  logic                                   i_user_end,
    input  logic [UPD_COUNT_WIDTH-1:0]             i_user_iq_noise_rate,
    input  logic                                   i_iq_valid,
    input  logic [DATA_WIDTH-1:0]                  i_iq_i,
    input  logic [DATA_WIDTH-1:0]                  i_iq_q,
    input  logic                                   i_noise_valid,
    input  logic [DATA_WIDTH-1:0]                  i_noise_data,
    input  logic                                   i_iq_fifo_full,
    input  logic                                   i_noise_fifo_full,
    output logic                                   o_iq_fifo_wr_en,
    output logic [IQ_RE_PER_WORD*2*DATA_WIDTH-1:0] o_iq_fifo_wr_data,
    output logic                                   o_noise_fifo_wr_en,
    output logic [NOISE_PER_WORD*DATA_WIDTH-1:0]   o_noise_fifo_wr_data,
    output logic [UPD_COUNT_WIDTH-1:0]             o_re_count,
    output logic [UPD_COUNT_WIDTH-1:0]             o_noise_count,
    output logic                                   o_overflow,
    output logic                                   o_noise_mismatch,
    output logic                                   o_user_done
);

    upd_state_e                 state_reg;
    logic [UPD_COUNT_WIDTH-1:0] re_count_reg;
    logic [UPD_COUNT_WIDTH-1:0] noise_count_reg;
    logic [UPD_COUNT_WIDTH-1:0] expected_reg;
    logic [UPD_COUNT_WIDTH-1:0] group_reg;
    logic                       overflow_reg;
    logic                       mismatch_reg;
    logic                       done_reg;

    logic                       in_pack;
    logic                       iq_accept;
    logic                       noise_accept;
    logic [UPD_COUNT_WIDTH-1:0] rate_eff;
    logic                       group_last;
    logic                       iq_drop;
    logic                       noise_drop;

    // A start pulse restarts the user, so samples in that cycle are not taken.
    assign in_pack      = (state_reg == ST_PACK) && !i_user_start;
    assign iq_accept    = in_pack && i_iq_valid;
    assign noise_accept = in_pack && i_noise_valid;

    assign rate_eff   = (i_user_iq_noise_rate == '0) ? UPD_COUNT_WIDTH'(1)
                                                     : i_user_iq_noise_rate;
    // Compare in 17 bits so the group counter closes correctly even when
    // the rate is at its maximum; using >= also recovers if the rate is
    // lowered mid-user.
    assign group_last = ({1'b0, group_reg} + 17'd1) >= {1'b0, rate_eff};

    upd_lane_packer #(
        .LANES      (IQ_RE_PER_WORD),
        .LANE_WIDTH (2 * DATA_WIDTH)
    ) u_iq_packer (
        .i_core_clk  (i_core_clk),
        .i_rx_rst    (i_rx_rst),
        .i_clear     (i_user_start),
        .i_valid     (iq_accept),
        .i_data      ({i_iq_q, i_iq_i}),
        .i_flush     (state_reg == ST_FLUSH_IQ),
        .i_fifo_full (i_iq_fifo_full),
        .o_wr_en     (o_iq_fifo_wr_en),
        .o_wr_data   (o_iq_fifo_wr_data),
        .o_drop      (iq_drop)
    );

    upd_lane_packer #(
        .LANES      (NOISE_PER_WORD),
        .LANE_WIDTH (DATA_WIDTH)
    ) u_noise_packer (
        .i_core_clk  (i_core_clk),
        .i_rx_rst    (i_rx_rst),
        .i_clear     (i_user_start),
        .i_valid     (noise_accept),
        .i_data      (i_noise_data),
        .i_flush     (state_reg == ST_FLUSH_NOISE),
        .i_fifo_full (i_noise_fifo_full),
        .o_wr_en     (o_noise_fifo_wr_en),
        .o_wr_data   (o_noise_fifo_wr_data),
        .o_drop      (noise_drop)
    );

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            state_reg       <= ST_IDLE;
            re_count_reg    <= '0;
            noise_count_reg <= '0;
            expected_reg    <= '0;
            group_reg       <= '0;
            overflow_reg    <= 1'b0;
            mismatch_reg    <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (i_user_start) begin
                state_reg       <= ST_PACK;
                re_count_reg    <= '0;
                noise_count_reg <= '0;
                expected_reg    <= '0;
                group_reg       <= '0;
                overflow_reg    <= 1'b0;
                mismatch_reg    <= 1'b0;
            end else begin
                if (iq_accept) begin
                    re_count_reg <= sat_inc(re_count_reg);
                    // The first RE of every noise group expects one noise
                    // sample, giving ceil(re_count / rate) overall.
                    if (group_reg == '0) begin
                        expected_reg <= sat_inc(expected_reg);
                    end
                    group_reg <= group_last ? '0 : group_reg + 1'b1;
                end
                if (noise_accept) begin
                    noise_count_reg <= sat_inc(noise_count_reg);
                end
                if (iq_drop || noise_drop) begin
                    overflow_reg <= 1'b1;
                end

                case (state_reg)
                    ST_IDLE: begin
                        state_reg <= ST_IDLE;
                    end
                    ST_PACK: begin
                        if (i_user_end) begin
                            state_reg <= ST_FLUSH_IQ;
                        end
                    end
                    ST_FLUSH_IQ: begin
                        state_reg <= ST_FLUSH_NOISE;
                    end
                    ST_FLUSH_NOISE: begin
                        // Both counts are final here: the last acceptance
                        // happened in the i_user_end cycle.
                        if (noise_count_reg != expected_reg) begin
                            mismatch_reg <= 1'b1;
                        end
                        state_reg <= ST_DONE;
                    end
                    ST_DONE: begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_re_count       = re_count_reg;
    assign o_noise_count    = noise_count_reg;
    assign o_overflow       = overflow_reg;
    assign o_noise_mismatch = mismatch_reg;
    assign o_user_done      = done_reg;

endmodule

// File: tb/tb_upd_fast_phy_packer.sv
// Testbench for upd_fast_phy_packer: directed user scenarios plus random
// users, checked against a list-based model of the packing/framing rules.
module tb_upd_fast_phy_packer;

    logic         clk = 1'b0;
    logic         i_rx_rst = 1'b1;
    logic         i_user_start = 1'b0;
    logic         i_user_end = 1'b0;
    logic [15:0]  i_user_iq_noise_rate = 16'd1;
    logic         i_iq_valid = 1'b0;
    logic [15:0]  i_iq_i = '0;
    logic [15:0]  i_iq_q = '0;
    logic         i_noise_valid = 1'b0;
    logic [15:0]  i_noise_data = '0;
    logic         i_iq_fifo_full = 1'b0;
    logic         i_noise_fifo_full = 1'b0;
    logic         o_iq_fifo_wr_en;
    logic [127:0] o_iq_fifo_wr_data;
    logic         o_noise_fifo_wr_en;
    logic [127:0] o_noise_fifo_wr_data;
    logic [15:0]  o_re_count;
    logic [15:0]  o_noise_count;
    logic         o_overflow;
    logic         o_noise_mismatch;
    logic         o_user_done;

    upd_fast_phy_packer dut (
        .i_core_clk           (clk),
        .i_rx_rst             (i_rx_rst),
        .i_user_start         (i_user_start),
        .i_user_end           (i_user_end),
        .i_user_iq_noise_rate (i_user_iq_noise_rate),
        .i_iq_valid           (i_iq_valid),
        .i_iq_i               (i_iq_i),
        .i_iq_q               (i_iq_q),
        .i_noise_valid        (i_noise_valid),
        .i_noise_data         (i_noise_data),
        .i_iq_fifo_full       (i_iq_fifo_full),
        .i_noise_fifo_full    (i_noise_fifo_full),
        .o_iq_fifo_wr_en      (o_iq_fifo_wr_en),
        .o_iq_fifo_wr_data    (o_iq_fifo_wr_data),
        .o_noise_fifo_wr_en   (o_noise_fifo_wr_en),
        .o_noise_fifo_wr_data (o_noise_fifo_wr_data),
        .o_re_count           (o_re_count),
        .o_noise_count        (o_noise_count),
        .o_overflow           (o_overflow),
        .o_noise_mismatch     (o_noise_mismatch),
        .o_user_done          (o_user_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [127:0] w;
    } wr_t;

    wr_t exp_iq[$];
    wr_t act_iq[$];
    wr_t exp_nz[$];
    wr_t act_nz[$];
    int  exp_done[$];
    int  act_done[$];

    // Model state for the user in progress.
    logic [31:0] m_iq[$];
    logic [15:0] m_nz[$];
    int          m_re = 0;
    int          m_noise = 0;
    bit          m_active = 0;
    bit          m_ovf = 0;
    bit          m_mm = 0;

    int n_checks = 0;
    int n_fail = 0;

    // Observed writes and done pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (o_iq_fifo_wr_en)    act_iq.push_back('{cyc, o_iq_fifo_wr_data});
        if (o_noise_fifo_wr_en) act_nz.push_back('{cyc, o_noise_fifo_wr_data});
        if (o_user_done)        act_done.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    function automatic logic [127:0] pack_iq();
        logic [127:0] w = '0;
        for (int k = 0; k < m_iq.size(); k++) w[32*k +: 32] = m_iq[k];
        return w;
    endfunction

    function automatic logic [127:0] pack_nz();
        logic [127:0] w = '0;
        for (int k = 0; k < m_nz.size(); k++) w[16*k +: 16] = m_nz[k];
        return w;
    endfunction

    task automatic model_clear();
        m_iq.delete();
        m_nz.delete();
        m_re = 0;
        m_noise = 0;
        m_ovf = 0;
        m_mm = 0;
    endtask

    // Drive one cycle of inputs, update the model, then advance one clock.
    task automatic drive(input bit iv, input logic [15:0] di, input logic [15:0] dq,
                         input bit nv, input logic [15:0] dn, input bit ue,
                         input bit fiq, input bit fnz, input bit st);
        int t;
        int r;
        t = cyc;
        i_iq_valid = iv;
        i_iq_i = di;
        i_iq_q = dq;
        i_noise_valid = nv;
        i_noise_data = dn;
        i_user_end = ue;
        i_iq_fifo_full = fiq;
        i_noise_fifo_full = fnz;
        i_user_start = st;
        if (st) begin
            model_clear();
            m_active = 1;
        end else if (m_active) begin
            if (iv) begin
                m_re++;
                m_iq.push_back({dq, di});
                if (m_iq.size() == 4) begin
                    if (!fiq) exp_iq.push_back('{t + 1, pack_iq()});
                    else m_ovf = 1;
                    m_iq.delete();
                end
            end
            if (nv) begin
                m_noise++;
                m_nz.push_back(dn);
                if (m_nz.size() == 8) begin
                    if (!fnz) exp_nz.push_back('{t + 1, pack_nz()});
                    else m_ovf = 1;
                    m_nz.delete();
                end
            end
            if (ue) begin
                // Flush cycles always run with the full flags low.
                m_active = 0;
                if (m_iq.size() > 0) exp_iq.push_back('{t + 2, pack_iq()});
                if (m_nz.size() > 0) exp_nz.push_back('{t + 3, pack_nz()});
                m_iq.delete();
                m_nz.delete();
                exp_done.push_back(t + 4);
                r = (i_user_iq_noise_rate == 16'd0) ? 1 : int'(i_user_iq_noise_rate);
                m_mm = (m_noise != (m_re + r - 1) / r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 16'd0, 16'd0, 0, 16'd0, 0, 0, 0, 0);
    endtask

    task automatic reset_cycle();
        int t;
        t = cyc;
        i_rx_rst = 1'b1;
        i_iq_valid = 0;
        i_noise_valid = 0;
        i_user_end = 0;
        i_user_start = 0;
        i_iq_fifo_full = 0;
        i_noise_fifo_full = 0;
        m_active = 0;
        model_clear();
        // Anything that would have appeared after this edge never happens.
        while (exp_iq.size() > 0 && exp_iq[$].cyc > t) void'(exp_iq.pop_back());
        while (exp_nz.size() > 0 && exp_nz[$].cyc > t) void'(exp_nz.pop_back());
        while (exp_done.size() > 0 && exp_done[$] > t) void'(exp_done.pop_back());
        @(posedge clk);
        #1;
        i_rx_rst = 1'b0;
    endtask

    task automatic compare_all(input string name);
        int n;
        chk({name, "_iq_nwr"}, 128'(act_iq.size()), 128'(exp_iq.size()));
        n = (act_iq.size() < exp_iq.size()) ? act_iq.size() : exp_iq.size();
        for (int k = 0; k < n; k++) begin
            chk({name, "_iq_word"}, act_iq[k].w, exp_iq[k].w);
            chk({name, "_iq_cyc"}, 128'(act_iq[k].cyc), 128'(exp_iq[k].cyc));
        end
        chk({name, "_nz_nwr"}, 128'(act_nz.size()), 128'(exp_nz.size()));
        n = (act_nz.size() < exp_nz.size()) ? act_nz.size() : exp_nz.size();
        for (int k = 0; k < n; k++) begin
            chk({name, "_nz_word"}, act_nz[k].w, exp_nz[k].w);
            chk({name, "_nz_cyc"}, 128'(act_nz[k].cyc), 128'(exp_nz[k].cyc));
        end
        chk({name, "_done_n"}, 128'(act_done.size()), 128'(exp_done.size()));
        n = (act_done.size() < exp_done.size()) ? act_done.size() : exp_done.size();
        for (int k = 0; k < n; k++) chk({name, "_done_cyc"}, 128'(act_done[k]), 128'(exp_done[k]));
        chk({name, "_re_count"}, 128'(o_re_count), 128'(m_re));
        chk({name, "_noise_count"}, 128'(o_noise_count), 128'(m_noise));
        chk({name, "_overflow"}, 128'(o_overflow), 128'(m_ovf));
        chk({name, "_mismatch"}, 128'(o_noise_mismatch), 128'(m_mm));
        exp_iq.delete();
        act_iq.delete();
        exp_nz.delete();
        act_nz.delete();
        exp_done.delete();
        act_done.delete();
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_iq_wr_en"}, 128'(o_iq_fifo_wr_en), 128'(0));
        chk({name, "_iq_wr_data"}, o_iq_fifo_wr_data, 128'(0));
        chk({name, "_nz_wr_en"}, 128'(o_noise_fifo_wr_en), 128'(0));
        chk({name, "_nz_wr_data"}, o_noise_fifo_wr_data, 128'(0));
        chk({name, "_re_count"}, 128'(o_re_count), 128'(0));
        chk({name, "_noise_count"}, 128'(o_noise_count), 128'(0));
        chk({name, "_overflow"}, 128'(o_overflow), 128'(0));
        chk({name, "_mismatch"}, 128'(o_noise_mismatch), 128'(0));
        chk({name, "_done"}, 128'(o_user_done), 128'(0));
    endtask

    initial begin
        logic [127:0] word0_req;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        i_rx_rst = 1'b0;
        check_all_zero("reset");
        idle(2);

        // Rate 2, 8 REs, 4 noise samples in the first four cycles.
        i_user_iq_noise_rate = 16'd2;
        drive(0, 16'd0, 16'd0, 0, 16'd0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++)
            drive(1, 16'(k), 16'(100 + k), k < 4, 16'(200 + k), k == 7, 0, 0, 0);
        idle(6);
        word0_req = {16'd103, 16'd3, 16'd102, 16'd2, 16'd101, 16'd1, 16'd100, 16'd0};
        if (act_iq.size() > 0) chk("plan1_word0", act_iq[0].w, word0_req);
        compare_all("plan1");

        // Rate 4, 5 REs, 2 noise samples: partial IQ flush with lane 0 only.
        i_user_iq_noise_rate = 16'd4;
        drive(0, 16'd0, 16'd0, 0, 16'd0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++)
            drive(1, 16'(10 + k), 16'(50 + k), k < 2, 16'(300 + k), k == 4, 0, 0, 0);
        idle(6);
        compare_all("plan2");

        // Rate 4, 9 REs, 2 noise samples: expected 3 -> mismatch.
        drive(0, 16'd0, 16'd0, 0, 16'd0, 0, 0, 0, 1);
        for (int k = 0; k < 9; k++)
            drive(1, 16'(k + 1), 16'(k + 2), k < 2, 16'(400 + k), k == 8, 0, 0, 0);
        idle(6);
        compare_all("plan3");

        // IQ FIFO full on the 4th RE: first word dropped, next word written.
        i_user_iq_noise_rate = 16'd0;
        drive(0, 16'd0, 16'd0, 0, 16'd0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++)
            drive(1, 16'(500 + k), 16'(600 + k), 1, 16'(700 + k), k == 7, k == 3, 0, 0);
        idle(6);
        compare_all("overflow");

        // Start mid-user after 3 REs: partial word discarded, counts cleared.
        i_user_iq_noise_rate = 16'd1;
        drive(0, 16'd0, 16'd0, 0, 16'd0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) drive(1, 16'(800 + k), 16'(900 + k), 1, 16'(k), 0, 0, 0, 0);
        drive(0, 16'd0, 16'd0, 0, 16'd0, 0, 0, 0, 1);
        chk("restart_re_count", 128'(o_re_count), 128'(0));
        chk("restart_noise_count", 128'(o_noise_count), 128'(0));
        for (int k = 0; k < 4; k++)
            drive(1, 16'(1000 + k), 16'(1100 + k), 1, 16'(1200 + k), k == 3, 0, 0, 0);
        idle(6);
        compare_all("restart");

        // Reset during FLUSH_IQ: no flush writes, everything back to zero.
        drive(0, 16'd0, 16'd0, 0, 16'd0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++)
            drive(1, 16'(1300 + k), 16'(1400 + k), 1, 16'(1500 + k), k == 2, 0, 0, 0);
        reset_cycle();
        check_all_zero("rst_flush");
        for (int k = 0; k < 3; k++) drive(1, 16'(k + 7), 16'(k + 9), 1, 16'(k), 0, 0, 0, 0);
        chk("idle_valid_re_count", 128'(o_re_count), 128'(0));
        idle(6);
        compare_all("rst_flush");

        // Random users.
        for (int u = 0; u < 10; u++) begin
            int n;
            i_user_iq_noise_rate = 16'($urandom_range(0, 5));
            n = $urandom_range(1, 30);
            drive(0, 16'd0, 16'd0, 0, 16'd0, 0, 0, 0, 1);
            for (int c = 0; c < n; c++)
                drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                      $urandom_range(0, 1) == 1, 16'($urandom), c == n - 1,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 0);
            idle(6);
            compare_all($sformatf("rand%0d", u));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/upd_fast_phy_packer.md
# upd_fast_phy_packer

Upstream feeder of the slow-PHY-to-LLR sender: it accepts one RE of IQ per cycle and one noise sample per noise group from the fast PHY. It packs them into 128-bit words and writes them into the IQ FIFO and the noise FIFO that the sender drains. It also handles per-user start/end framing, flushing of partial words, FIFO-overflow detection and an IQ/noise count consistency check.

## Interface
- DATA_WIDTH, 16: width of each I, Q and noise sample.
- IQ_RE_PER_WORD, 4: REs per IQ FIFO word (4 × (I,Q) × 16 = 128 bits).
- NOISE_PER_WORD, 8: noise samples per noise FIFO word (8 × 16 = 128 bits).
- i_core_clk  in  1  single clock for all logic.
- i_rx_rst  in  1  reset; synchronous, active-high.
- i_user_start  in  1  one-cycle pulse; begins a user and clears all counters and flags.
- i_user_end  in  1  one-cycle pulse; last sample of the user has been presented.
- i_user_iq_noise_rate  in  16  REs covered by one noise sample; 0 is treated as 1.
- i_iq_valid  in  1  IQ sample present.
- i_iq_i, i_iq_q  in  16 each  IQ sample of one RE.
- i_noise_valid  in  1  noise sample present.
- i_noise_data  in  16  noise sample.
- i_iq_fifo_full, i_noise_fifo_full  in  1 each  almost-full flags; must guarantee at least one free slot when low.
- o_iq_fifo_wr_en, o_noise_fifo_wr_en  out  1 each  write strobes.
- o_iq_fifo_wr_data, o_noise_fifo_wr_data  out  128 each  packed words.
- o_re_count  out  16  REs accepted for the current user.
- o_noise_count  out  16  noise samples accepted for the current user.
- o_overflow  out  1  sticky; at least one word was dropped because the FIFO was full.
- o_noise_mismatch  out  1  sticky; noise count disagreed with expectation at user end.
- o_user_done  out  1  one-cycle pulse when the flush is complete.

## Operation
- FSM states: IDLE, PACK, FLUSH_IQ, FLUSH_NOISE, DONE.
  - IDLE→PACK on i_user_start.
  - PACK→FLUSH_IQ on i_user_end.
  - FLUSH_IQ→FLUSH_NOISE after 1 cycle.
  - FLUSH_NOISE→DONE after 1 cycle.
  - DONE→IDLE after 1 cycle.
  - i_user_start in any state forces PACK with counters cleared; partial words are discarded and not written.
- Valid inputs are ignored outside PACK. A valid sample in the same cycle as i_user_end is accepted and included in the flush.
- IQ lane k of a word (k = 0..3, in arrival order):
  - I at bits [32k+15:32k].
  - Q at bits [32k+31:32k+16].
- Noise sample k of a word (k = 0..7) at bits [16k+15:16k].
- When a word completes (4th RE or 8th noise sample):
  - FIFO full low: write the word.
  - FIFO full high: drop the word, set o_overflow, and keep counting.
  - In both cases the lane index wraps to 0.
- Flush:
  - FLUSH_IQ writes the partial IQ word with unfilled lanes zeroed, only if lane index ≠ 0.
  - FLUSH_NOISE does the same for the noise word.
  - Full-flag handling is identical to normal writes.
- Expected noise count:
  - A group counter runs 0..rate-1 over accepted REs.
  - Every RE accepted while the group counter = 0 increments the expected count, i.e. expected = ceil(re_count / rate).
  - In FLUSH_NOISE, o_noise_mismatch is set if o_noise_count ≠ expected.
- Counters saturate at 16'hFFFF and do not wrap.

## Timing
- Reset values: all outputs 0, FSM in IDLE, lane indices 0.
- Write strobes and data are registered. A write appears the cycle after the completing sample is accepted.
- Full flags are sampled in the same cycle as the completing sample.
- o_re_count and o_noise_count update the cycle after acceptance.
- Partial IQ write: the cycle after FSM enters FLUSH_IQ, i.e. 2 cycles after i_user_end.
- Partial noise write: 3 cycles after i_user_end.
- o_user_done and o_noise_mismatch: valid 4 cycles after i_user_end.
- Sticky flags and counts hold until the next i_user_start or reset.
- Reset mid-user: everything returns to reset values on the next edge, with no flush writes.
- Throughput: one IQ RE and one noise sample per cycle, with no backpressure to the source.

## Structure
- Package upd_pkg holds:
  - DATA_WIDTH, FIFO word width 128, IQ_RE_PER_WORD, NOISE_PER_WORD.
  - The FSM state enum.
- Sub-module upd_lane_packer, parameterised by LANES and LANE_WIDTH:
  - Contains the lane index, shift/insert register, completion flag, zero-padded flush output and the drop decision.
  - Instantiated twice: 4×32-bit for IQ and 8×16-bit for noise.
- The top level holds the FSM, the counters, expected-count logic and the flags.

## Test plan
- Rate 2; 8 REs with I=k, Q=100+k, plus 4 noise samples 200..203; end → exactly 2 IQ writes and 0 noise writes in PACK, then 1 noise write in FLUSH_NOISE with lanes 4..7 = 0. Word 0 = {Q3,I3,…,Q0,I0}. Mismatch 0, o_user_done 4 cycles after end.
- 5 REs, rate 4, 2 noise samples → 1 full IQ write, then a flush IQ word with only lane 0 (I4/Q4) nonzero; expected = 2, mismatch 0.
- 9 REs, rate 4, 2 noise samples → expected 3, o_noise_mismatch = 1.
- i_iq_fifo_full held high while the 4th RE is accepted → no write for that word, o_overflow = 1; the next 4 REs write normally.
- i_user_start asserted mid-user after 3 REs → no write of the partial word, counts read 0, and the next 4 REs form a clean word.
- i_rx_rst asserted during FLUSH_IQ → no flush writes, all outputs 0 the next cycle; i_iq_valid in IDLE is ignored (count stays 0).
